// File: rtl/lmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : lmem_pkg
// Purpose : Shared types and widths for the local memory arbiter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package lmem_pkg;

  // Arbiter lock state: IDLE arbitrates round-robin, LOCKED serves one owner.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int LMEM_DATA_W = 128;
  localparam int LMEM_ADDR_W = 32;

endpackage : lmem_pkg
`default_nettype wire

// File: rtl/local_mem_arb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : rr_pick
// Purpose : Combinational round-robin picker. The port indexed by i_ptr has
//           the highest priority, then i_ptr+1, wrapping around.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant
);

  int   w_idx;
  logic w_found;

  // Walk the ports starting at the pointer and grant the first requester.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_PORTS;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/local_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : local_mem_arb
// Purpose : Arbitrates NUM_PORTS requesters onto a single banked local
//           memory port. Round-robin with an optional bounded lock, and
//           1-cycle read responses routed back to the issuing port.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module local_mem_arb
  import lmem_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int MAX_LOCK_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_lock,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS-1:0]             req_is_vector,
  input  logic [2*NUM_PORTS-1:0]           req_bank_sel,
  input  logic [LMEM_ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [LMEM_DATA_W*NUM_PORTS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [LMEM_DATA_W-1:0]           resp_rdata,
  output logic                             mem_req_valid,
  output logic                             mem_req_we,
  output logic                             mem_req_is_vector,
  output logic [1:0]                       mem_req_bank_sel,
  output logic [LMEM_ADDR_W-1:0]           mem_req_addr,
  output logic [LMEM_DATA_W-1:0]           mem_req_wdata,
  input  logic [LMEM_DATA_W-1:0]           mem_resp_rdata
);

  localparam int                 c_PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int                 c_CNT_W     = $clog2(MAX_LOCK_BEATS + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_PORT = c_PTR_W'(NUM_PORTS - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_LOCK_BEATS - 1);

  arb_state_e           r_state;
  logic [c_PTR_W-1:0]   r_owner;
  logic [c_CNT_W-1:0]   r_beat_cnt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic                 r_rd_pend;
  logic [c_PTR_W-1:0]   r_rd_owner;

  logic [NUM_PORTS-1:0] w_pick;
  logic [NUM_PORTS-1:0] w_owner_oh;
  logic [c_PTR_W-1:0]   w_gnt_idx;
  logic                 w_fire;

  // Pointer value that puts the port after p at the head of the rotation.
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (c_PTR_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // Grant: round-robin pick when idle, only a valid owner while locked.
  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
    if (rst) begin
      req_ready = '0;
    end else if (r_state == LOCKED) begin
      req_ready = w_owner_oh & req_valid;
    end else begin
      req_ready = w_pick;
    end
  end

  // Encode the one-hot grant and steer the winner's fields to memory.
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_ready[i]) begin
        w_gnt_idx = c_PTR_W'(i);
      end
    end
    w_fire            = |(req_valid & req_ready);
    mem_req_valid     = w_fire;
    mem_req_we        = req_we[w_gnt_idx];
    mem_req_is_vector = req_is_vector[w_gnt_idx];
    mem_req_bank_sel  = req_bank_sel[w_gnt_idx*2 +: 2];
    mem_req_addr      = req_addr[w_gnt_idx*LMEM_ADDR_W +: LMEM_ADDR_W];
    mem_req_wdata     = req_wdata[w_gnt_idx*LMEM_DATA_W +: LMEM_DATA_W];
  end

  // Lock FSM and round-robin pointer; the pointer only moves on an idle
  // transfer or when a lock is released (voluntarily or at the beat cap).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_ptr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_ptr <= f_next(w_gnt_idx);
            if (req_lock[w_gnt_idx] && (MAX_LOCK_BEATS > 1)) begin
              r_state    <= LOCKED;
              r_owner    <= w_gnt_idx;
              r_beat_cnt <= c_CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (w_fire) begin
            if (!req_lock[r_owner] || (r_beat_cnt == c_LAST_BEAT)) begin
              r_state    <= IDLE;
              r_ptr      <= f_next(r_owner);
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Remember who issued a read so its data can be routed next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= '0;
    end else begin
      r_rd_pend <= w_fire && !mem_req_we;
      if (w_fire) begin
        r_rd_owner <= w_gnt_idx;
      end
    end
  end

  // Strobe the read owner; data comes straight from the memory.
  always_comb begin
    resp_valid = '0;
    if (r_rd_pend) begin
      resp_valid[r_rd_owner] = 1'b1;
    end
  end

  assign resp_rdata = mem_resp_rdata;

endmodule : local_mem_arb
`default_nettype wire

// File: tb/tb_local_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_local_mem_arb
// Purpose : Directed scoreboard bench for local_mem_arb with a small banked
//           memory model behind the arbiter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_local_mem_arb;
  import lmem_pkg::*;

  localparam int NP   = 3;
  localparam int MAXB = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       req_valid, req_ready, req_lock, req_we, req_is_vector;
  logic [2*NP-1:0]     req_bank_sel;
  logic [32*NP-1:0]    req_addr;
  logic [128*NP-1:0]   req_wdata;
  logic [NP-1:0]       resp_valid;
  logic [127:0]        resp_rdata;
  logic                mem_req_valid, mem_req_we, mem_req_is_vector;
  logic [1:0]          mem_req_bank_sel;
  logic [31:0]         mem_req_addr;
  logic [127:0]        mem_req_wdata;
  logic [127:0]        mem_resp_rdata;

  local_mem_arb #(.NUM_PORTS(NP), .MAX_LOCK_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_we(req_we), .req_is_vector(req_is_vector), .req_bank_sel(req_bank_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_is_vector(mem_req_is_vector), .mem_req_bank_sel(mem_req_bank_sel),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           gap;
    logic         we;
    logic         vec;
    logic         lock;
    logic [1:0]   bank;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } beat_t;

  typedef struct {
    int           port;
    logic [127:0] data;
  } resp_t;

  beat_t   pq [NP][$];
  int      exp_gnt[$];
  resp_t   exp_resp[$];
  logic [NP-1:0] in_gap;
  int      n_checks = 0;
  int      n_fail   = 0;

  // Background memory contents: each 32-bit lane of word w holds 0xA500_0000|w.
  function automatic logic [127:0] pat(input int w);
    logic [31:0] lane;
    lane = 32'hA500_0000 | 32'(w);
    return {lane, lane, lane, lane};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_beat(input int p, input int gap, input logic we, input logic vec,
                           input logic lock, input logic [1:0] bank,
                           input logic [31:0] addr, input logic [127:0] wd);
    beat_t b;
    b.gap = gap; b.we = we; b.vec = vec; b.lock = lock;
    b.bank = bank; b.addr = addr; b.wdata = wd;
    pq[p].push_back(b);
  endtask

  task automatic exp_r(input int p, input logic [127:0] d);
    resp_t r;
    r.port = p; r.data = d;
    exp_resp.push_back(r);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((pq[0].size() + pq[1].size() + pq[2].size() + exp_gnt.size() + exp_resp.size()) != 0
           && c < 300) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 300) begin
      n_fail++;
      $display("FAIL %s_drain: %0d grants and %0d responses still outstanding, expected 0",
               nm, exp_gnt.size(), exp_resp.size());
      for (int p = 0; p < NP; p++) pq[p].delete();
      exp_gnt.delete();
      exp_resp.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Memory model: scalar writes update one 32-bit lane, reads return the
  // whole 128-bit word one cycle later.
  logic [127:0] mem [0:63];
  logic [63:0]  mem_wr;
  logic [127:0] mem_cur;
  always @(posedge clk) begin
    if (rst) begin
      mem_wr <= '0;
    end else if (mem_req_valid) begin
      mem_cur = mem_wr[mem_req_addr[9:4]] ? mem[mem_req_addr[9:4]] : pat(int'(mem_req_addr[9:4]));
      if (mem_req_we) begin
        if (mem_req_is_vector) mem_cur = mem_req_wdata;
        else mem_cur[32*mem_req_bank_sel +: 32] = mem_req_wdata[31:0];
        mem[mem_req_addr[9:4]]    <= mem_cur;
        mem_wr[mem_req_addr[9:4]] <= 1'b1;
      end else begin
        mem_resp_rdata <= mem_cur;
      end
    end
  end

  // Requester driver: holds each queued beat until it is handshaken.
  logic [NP-1:0] drv_hs;
  beat_t         drv_b;
  initial begin
    req_valid = '0; req_lock = '0; req_we = '0; req_is_vector = '0;
    req_bank_sel = '0; req_addr = '0; req_wdata = '0; in_gap = '0;
    forever begin
      @(negedge clk);
      drv_hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (drv_hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        in_gap[p]    = 1'b0;
        req_valid[p] = 1'b0;
        req_lock[p]  = 1'b0;
        if (pq[p].size() > 0) begin
          drv_b = pq[p][0];
          if (drv_b.gap > 0) begin
            drv_b.gap--;
            pq[p][0]  = drv_b;
            in_gap[p] = 1'b1;
          end else begin
            req_valid[p]            = 1'b1;
            req_lock[p]             = drv_b.lock;
            req_we[p]               = drv_b.we;
            req_is_vector[p]        = drv_b.vec;
            req_bank_sel[2*p +: 2]  = drv_b.bank;
            req_addr[32*p +: 32]    = drv_b.addr;
            req_wdata[128*p +: 128] = drv_b.wdata;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a grant or a response appears.
  logic [NP-1:0] m_hs;
  int            m_gp;
  logic          m_last_rd = 1'b0;
  int            m_last_port = 0;
  resp_t         m_r;
  always @(negedge clk) begin
    m_hs = req_valid & req_ready;
    m_gp = 0;
    for (int i = 0; i < NP; i++) if (m_hs[i]) m_gp = i;
    check("ready_onehot", 128'($countones(req_ready) <= 1), 128'(1));
    if (m_hs != '0) begin
      check("mem_addr_mux", 128'(mem_req_addr), 128'(req_addr[32*m_gp +: 32]));
      if (exp_gnt.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL grant_unexpected: port %0d granted, expected no grant", m_gp);
      end else begin
        check("grant_port", 128'(m_gp), 128'(exp_gnt.pop_front()));
      end
    end
    if (resp_valid != '0) begin
      check("resp_latency", 128'(resp_valid),
            m_last_rd ? 128'(NP'(1) << m_last_port) : 128'(0));
      if (exp_resp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL resp_unexpected: resp_valid %b, expected none", resp_valid);
      end else begin
        m_r = exp_resp.pop_front();
        check("resp_port", 128'(resp_valid), 128'(NP'(1) << m_r.port));
        check("resp_data", resp_rdata, m_r.data);
      end
    end else if (m_last_rd && !rst) begin
      n_checks++; n_fail++;
      $display("FAIL resp_missing: resp_valid 0, expected port %0d", m_last_port);
    end
    m_last_rd   = (m_hs != '0) && !mem_req_we && !rst;
    m_last_port = m_gp;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int gap_seen;
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Three reading ports, two beats each: plain rotation 0,1,2,0,1,2.
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) begin
        push_beat(p, 0, 1'b0, 1'b0, 1'b0, 2'd0, 32'(p * 16), '0);
        exp_gnt.push_back(p);
        exp_r(p, pat(p));
      end
    @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_mem_valid", 128'(mem_req_valid), 128'(0));
    check("rst_state", 128'(dut.r_state), 128'(IDLE));
    check("rst_ptr", 128'(dut.r_ptr), 128'(0));
    check("rst_cnt", 128'(dut.r_beat_cnt), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("rr");

    // Port 1 locks for 4 beats while port 0 waits.
    for (int k = 0; k < 4; k++) begin
      push_beat(1, 0, 1'b0, 1'b0, (k < 3), 2'd0, 32'h10, '0);
      exp_gnt.push_back(1);
      exp_r(1, pat(1));
    end
    push_beat(0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h00, '0);
    exp_gnt.push_back(0);
    exp_r(0, pat(0));
    wait_idle("lock4");

    // Port 2 writes with lock held for 20 beats; cap forces release at 16.
    for (int k = 0; k < 20; k++)
      push_beat(2, 0, 1'b1, 1'b1, (k < 19), 2'd0, 32'hA0, 128'(k));
    push_beat(0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h30, '0);
    for (int k = 0; k < 16; k++) exp_gnt.push_back(2);
    exp_gnt.push_back(0);
    exp_r(0, pat(3));
    for (int k = 0; k < 4; k++) exp_gnt.push_back(2);
    wait_idle("lock_cap");
    check("cap_state", 128'(dut.r_state), 128'(IDLE));

    // Scalar write into bank 2, then a vector read of the same word.
    push_beat(0, 0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 128'hDEADBEEF);
    push_beat(1, 1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h40, '0);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_r(1, 128'hA5000004_DEADBEEF_A5000004_A5000004);
    wait_idle("wr_rd");

    // Locked port 1 drops valid for 3 cycles mid-lock.
    push_beat(1, 0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h50, '0);
    push_beat(1, 0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h50, '0);
    push_beat(1, 3, 1'b0, 1'b0, 1'b1, 2'd0, 32'h50, '0);
    push_beat(1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h50, '0);
    push_beat(0, 1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h60, '0);
    for (int k = 0; k < 4; k++) begin
      exp_gnt.push_back(1);
      exp_r(1, pat(5));
    end
    exp_gnt.push_back(0);
    exp_r(0, pat(6));
    gap_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_gap[1]) begin
        gap_seen++;
        check("gap_ready", 128'(req_ready), 128'(0));
        check("gap_cnt", 128'(dut.r_beat_cnt), 128'(2));
        check("gap_state", 128'(dut.r_state), 128'(LOCKED));
      end
      if (pq[1].size() == 0) break;
    end
    check("gap_cycles", 128'(gap_seen), 128'(3));
    wait_idle("gap");

    // Reset right after a locked port-2 read grant.
    push_beat(2, 0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h90, '0);
    exp_gnt.push_back(2);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_resp_valid", 128'(resp_valid), 128'(0));
    push_beat(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h70, '0);
    push_beat(1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h80, '0);
    @(negedge clk);
    check("rst2_ready", 128'(req_ready), 128'(0));
    check("rst2_mem_valid", 128'(mem_req_valid), 128'(0));
    check("rst2_resp_hold", 128'(resp_valid), 128'(0));
    check("rst2_state", 128'(dut.r_state), 128'(IDLE));
    check("rst2_ptr", 128'(dut.r_ptr), 128'(0));
    check("rst2_cnt", 128'(dut.r_beat_cnt), 128'(0));
    exp_gnt.push_back(0);
    exp_r(0, pat(7));
    exp_gnt.push_back(1);
    exp_r(1, pat(8));
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_local_mem_arb
`default_nettype wire

// File: doc/local_mem_arb.md
LOCAL_MEM_ARB -- requirements
Module: local_mem_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of requesters (port 0 scalar LSU, 1 vector LSU, 2 DMA).
REQ-002 SHALL have parameter MAX_LOCK_BEATS, default 16, maximum consecutive grants one locked owner may hold.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_PORTS  per-port request valid.
REQ-006 SHALL have port req_ready  output  NUM_PORTS  per-port grant; a beat transfers when valid and ready are both high.
REQ-007 SHALL have port req_lock  input  NUM_PORTS  requester asks to keep the grant for its next beat.
REQ-008 SHALL have port req_we, req_is_vector  input  NUM_PORTS each  per-port write enable and 128-bit vector access flag.
REQ-009 SHALL have port req_bank_sel  input  2*NUM_PORTS  per-port scalar bank select.
REQ-010 SHALL have port req_addr  input  32*NUM_PORTS  per-port byte address.
REQ-011 SHALL have port req_wdata  input  128*NUM_PORTS  per-port write data.
REQ-012 SHALL have port resp_valid  output  NUM_PORTS  read-data strobe to the owning port.
REQ-013 SHALL have port resp_rdata  output  128  read data broadcast; qualified by resp_valid.
REQ-014 SHALL have ports mem_req_valid, mem_req_we, mem_req_is_vector (output 1 each), mem_req_bank_sel (output 2), mem_req_addr (output 32), mem_req_wdata (output 128)  drive the banked local memory.
REQ-015 SHALL have port mem_resp_rdata  input  128  memory read data, valid one cycle after the read beat.

Function
REQ-016 SHALL grant at most one port per cycle; req_ready is one-hot or zero.
REQ-017 SHALL select combinationally among valid ports by round-robin, starting from the port after the last granted port.
REQ-018 SHALL, after reset, set the round-robin pointer so that port 0 has the highest priority.
REQ-019 SHALL drive mem_req_valid = |(req_valid & req_ready) and mux the granted port's fields to mem_req_*; mem_req_* are don't-care when mem_req_valid is low.
REQ-020 SHALL run an FSM with states IDLE and LOCKED.
REQ-021 SHALL go from IDLE to LOCKED when the granted beat has req_lock=1; it records the owner and sets the beat count to 1.
REQ-022 SHALL, in LOCKED, grant only the owner, increment the beat count on each owner beat, and return to IDLE on the first owner beat with req_lock=0.
REQ-023 SHALL, in LOCKED, insert zero-grant cycles while the owner has req_valid low; the beat count does not advance in those cycles.
REQ-024 SHALL force a return to IDLE and move the round-robin pointer past the owner when the beat count reaches MAX_LOCK_BEATS, even if req_lock=1.
REQ-025 SHALL update the round-robin pointer only on a transferred beat made in IDLE, or on a forced or voluntary release from LOCKED.
REQ-026 SHALL register the owner id and a read flag for each non-write beat; the next cycle it drives resp_valid[owner]=1 and passes resp_rdata = mem_resp_rdata unregistered, giving 1-cycle read latency.
REQ-027 SHALL accept back-to-back reads from different ports every cycle with no bubble; each response is routed to the port that issued that read.
REQ-028 SHALL never assert resp_valid for write beats.
REQ-029 SHALL have no response backpressure; requesters must accept resp_valid when it is asserted.

Reset
REQ-030 SHALL, while rst is high, drive req_ready=0, resp_valid=0 and mem_req_valid=0, and hold the FSM in IDLE with beat count 0 and the pointer at port 0.
REQ-031 SHALL, if reset is asserted mid-lock or while a read response is pending, abandon the lock and drop the pending response; no resp_valid appears after reset is released.

Structure
REQ-032 SHALL place the arb_state_e enum (IDLE, LOCKED) and the localparams LMEM_DATA_W=128 and LMEM_ADDR_W=32 in a shared package, lmem_pkg.
REQ-033 SHALL implement the round-robin pick as a sub-module, rr_pick (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-034 SHALL cover: ports 0, 1 and 2 valid every cycle, reads only -> grants follow 0,1,2,0,1,2 and each resp_valid arrives exactly 1 cycle after its grant.
REQ-035 SHALL cover: port 1 locked with req_lock=1 for 4 beats while port 0 is valid -> port 0 is blocked for 4 beats and granted on the cycle after port 1 releases.
REQ-036 SHALL cover: port 2 holds req_lock=1 for 20 beats -> forced release after beat 16 and the next grant goes to a waiting port 0 or 1.
REQ-037 SHALL cover: port 0 writes 0xDEADBEEF to address 0x40, bank 2, then port 1 reads vector address 0x40 -> resp_valid[1] is set and resp_rdata[95:64]=0xDEADBEEF; no resp_valid is seen for the write.
REQ-038 SHALL cover: port 1 in LOCKED drops req_valid for 3 cycles -> zero grants in those cycles and the beat count does not change.
REQ-039 SHALL cover: rst asserted on the cycle after a port 2 read grant -> resp_valid stays 0, and after release the FSM is in IDLE and the pointer is at port 0.
